// File: rtl/imem_loader_if.sv
// Loader-side signals of imem_loader: UART byte strobe in, load control and status out.
// rx_valid is a one-cycle strobe with no back-pressure; rx_data is valid only in that cycle.
interface imem_loader_if #(
    parameter int DEPTH_LOG2 = 12
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  load_start;
    logic                  cpu_hold;
    logic                  load_done;
    logic [DEPTH_LOG2:0]   load_count;
    logic                  overflow;

    modport master (
        output rx_valid, rx_data, load_start,
        input  cpu_hold, load_done, load_count, overflow
    );

    modport slave (
        input  rx_valid, rx_data, load_start,
        output cpu_hold, load_done, load_count, overflow
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with synchronous read plus a length-prefixed UART program loader
// that holds the CPU while it writes the memory word by word.
module imem_loader #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [31:0] instr,
    output logic        misaligned,
    output logic [2:0]  dbg_state,
    imem_loader_if.slave ld
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t       state, state_nx;
    logic [15:0]  len;
    logic [1:0]   byte_cnt;
    logic [23:0]  byte_buf;
    logic [15:0]  wcnt;
    logic         overflow_q;
    logic         hold;
    logic         word_fire;
    logic         in_range;
    logic [31:0]  mem [DEPTH];

    // wcnt is both the write address and the count of words consumed so far.
    assign word_fire = (state == DATA) && ld.rx_valid && (byte_cnt == 2'd3);
    assign in_range  = {16'd0, wcnt} < 32'(DEPTH);
    assign hold      = (state != RUN);

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        ld.cpu_hold  = hold;
        ld.load_done = 1'b0;
        case (state)
            RUN:    if (ld.load_start) state_nx = LEN_LO;
            LEN_LO: if (ld.rx_valid) state_nx = LEN_HI;
            LEN_HI: if (ld.rx_valid) state_nx = ({ld.rx_data, len[7:0]} == 16'd0) ? DONE : DATA;
            DATA:   if (word_fire && (wcnt + 16'd1 == len)) state_nx = DONE;
            DONE: begin
                ld.load_done = 1'b1;
                state_nx     = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len        <= 16'd0;
            byte_cnt   <= 2'd0;
            byte_buf   <= 24'd0;
            wcnt       <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                RUN: if (ld.load_start) begin
                    wcnt       <= 16'd0;
                    overflow_q <= 1'b0;
                    byte_cnt   <= 2'd0;
                end
                LEN_LO: if (ld.rx_valid) len[7:0]  <= ld.rx_data;
                LEN_HI: if (ld.rx_valid) len[15:8] <= ld.rx_data;
                DATA: if (ld.rx_valid) begin
                    // Bytes shift in from the top so byte 0 ends up in bits [7:0].
                    byte_cnt <= byte_cnt + 2'd1;
                    byte_buf <= {ld.rx_data, byte_buf[23:8]};
                    if (byte_cnt == 2'd3) begin
                        wcnt <= wcnt + 16'd1;
                        if (!in_range) overflow_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately outside reset so a program survives a CPU reset.
    always_ff @(posedge clock) begin
        if (word_fire && in_range) mem[wcnt[DEPTH_LOG2-1:0]] <= {ld.rx_data, byte_buf};
    end

    always_ff @(posedge clock) begin
        if (reset || hold) instr <= NOP_WORD;
        else               instr <= mem[pc[DEPTH_LOG2+1:2]];
    end

    assign ld.load_count = wcnt[DEPTH_LOG2:0];
    assign ld.overflow   = overflow_q;
    assign misaligned    = |pc[1:0];
    assign dbg_state     = state;

    logic unused_pc;
    assign unused_pc = ^pc[15:DEPTH_LOG2+2];
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 4096-word and a 4-word instance share one UART stream and are
// compared against a word-level model of what each load should leave in memory.
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [15:0] pc_big, pc_small;
    logic [31:0] instr_big, instr_small;
    logic        mis_big, mis_small;
    logic [2:0]  st_big, st_small;
    logic        rx_valid, load_start;
    logic [7:0]  rx_data;

    imem_loader_if #(.DEPTH_LOG2(12)) lb();
    imem_loader_if #(.DEPTH_LOG2(2))  ls();

    assign lb.rx_valid = rx_valid;  assign lb.rx_data = rx_data;  assign lb.load_start = load_start;
    assign ls.rx_valid = rx_valid;  assign ls.rx_data = rx_data;  assign ls.load_start = load_start;

    imem_loader #(.DEPTH_LOG2(12)) dut_big (
        .clock(clock), .reset(reset), .pc(pc_big), .instr(instr_big),
        .misaligned(mis_big), .dbg_state(st_big), .ld(lb)
    );
    imem_loader #(.DEPTH_LOG2(2)) dut_small (
        .clock(clock), .reset(reset), .pc(pc_small), .instr(instr_small),
        .misaligned(mis_small), .dbg_state(st_small), .ld(ls)
    );

    // ---------------- scoreboard / model ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int done_big = 0;
    int done_small = 0;
    logic [31:0] mdl_big [int];
    logic [31:0] mdl_small [int];
    logic [31:0] exp_q [$];

    always @(negedge clock) begin
        if (lb.load_done) done_big++;
        if (ls.load_done) done_small++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Word k of a stream is bytes 2+4k .. 5+4k, little-endian; words past the depth are dropped.
    task automatic model_load(input logic [7:0] s[$], input int words);
        for (int k = 0; k < words; k++) begin
            logic [31:0] w;
            w = {s[4*k+5], s[4*k+4], s[4*k+3], s[4*k+2]};
            if (k < 4096) mdl_big[k] = w;
            if (k < 4)    mdl_small[k] = w;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // A byte strobe rides along with load_start to show it is not taken as the length.
    task automatic start_load(input string tag);
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h55;
        @(negedge clock);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        check({tag, "_hold_big"},   32'(lb.cpu_hold), 32'd1);
        check({tag, "_hold_small"}, 32'(ls.cpu_hold), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((lb.cpu_hold || ls.cpu_hold) && t < 50) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_release"}, 32'(t < 50), 32'd1);
    endtask

    task automatic read_words(input int k, input string tag);
        pc_big   = {2'($urandom_range(0, 3)), 12'(k), 2'b00};
        pc_small = {12'($urandom), 2'(k), 2'b00};
        @(negedge clock);
        if (mdl_big.exists(k)) begin
            exp_q.push_back(mdl_big[k]);
            check({tag, "_rd_big"}, instr_big, exp_q.pop_front());
        end
        if (mdl_small.exists(k % 4)) begin
            exp_q.push_back(mdl_small[k % 4]);
            check({tag, "_rd_small"}, instr_small, exp_q.pop_front());
        end
    endtask

    // poke_at >= 0 pulses load_start after that many stream bytes (must be ignored).
    task automatic run_load(input logic [7:0] s[$], input string tag, input int poke_at);
        int n, d0b, d0s;
        n   = int'({s[1], s[0]});
        d0b = done_big;
        d0s = done_small;
        start_load(tag);
        foreach (s[i]) begin
            if (i == poke_at) begin
                load_start = 1'b1;
                @(negedge clock);
                load_start = 1'b0;
            end
            send_byte(s[i], (i == s.size() - 1) ? 0 : $urandom_range(0, 2));
        end
        wait_idle(tag);
        check({tag, "_nop_big"},   instr_big,   NOP);
        check({tag, "_nop_small"}, instr_small, NOP);
        model_load(s, n);
        @(negedge clock);
        check({tag, "_done_big"},   32'(done_big - d0b),   32'd1);
        check({tag, "_done_small"}, 32'(done_small - d0s), 32'd1);
        check({tag, "_cnt_big"},   32'(lb.load_count), 32'(n % 8192));
        check({tag, "_cnt_small"}, 32'(ls.load_count), 32'(n % 8));
        check({tag, "_ovf_big"},   32'(lb.overflow), 32'(n > 4096));
        check({tag, "_ovf_small"}, 32'(ls.overflow), 32'(n > 4));
        for (int k = 0; k < n; k++) read_words(k, tag);
    endtask

    function automatic void rand_stream(output logic [7:0] s[$], input int n);
        s = {};
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] s[$];
        reset = 1'b1; pc_big = 16'd0; pc_small = 16'd0;
        rx_valid = 1'b0; rx_data = 8'd0; load_start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_instr_big",   instr_big,   NOP);
        check("rst_instr_small", instr_small, NOP);
        reset = 1'b0;
        @(negedge clock);
        check("rst_hold",     32'(lb.cpu_hold),   32'd0);
        check("rst_cnt",      32'(lb.load_count), 32'd0);
        check("rst_ovf",      32'(lb.overflow),   32'd0);
        check("rst_done",     32'(lb.load_done),  32'd0);

        s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        run_load(s, "prog", -1);
        pc_big = 16'h0000; @(negedge clock);
        check("prog_word0", instr_big, 32'h0050_0093);
        pc_big = 16'h0004; @(negedge clock);
        check("prog_word1", instr_big, 32'h00A0_0113);

        rand_stream(s, 5);
        run_load(s, "ovf5", -1);
        pc_small = 16'd16; @(negedge clock);
        check("wrap_small", instr_small, mdl_small[0]);

        for (int r = 0; r < 3; r++) begin
            rand_stream(s, $urandom_range(1, 7));
            run_load(s, $sformatf("rnd%0d", r), -1);
        end

        s = {8'h00, 8'h00};
        run_load(s, "len0", -1);
        for (int k = 0; k < 4; k++) read_words(k, "len0_keep");

        pc_big = 16'h0002; pc_small = 16'h0002;
        #1;
        check("mis_big",   32'(mis_big),   32'd1);
        check("mis_small", 32'(mis_small), 32'd1);
        @(negedge clock);
        check("mis_rd_big", instr_big, mdl_big[0]);
        pc_big = 16'h0000; #1;
        check("mis_clear", 32'(mis_big), 32'd0);
        @(negedge clock);

        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        check("run_rx_hold", 32'(lb.cpu_hold), 32'd0);
        for (int k = 0; k < 4; k++) read_words(k, "run_rx");

        rand_stream(s, 2);
        run_load(s, "poke", 6);

        // Reset after the first full word and two bytes of the second.
        rand_stream(s, 3);
        start_load("mid");
        for (int i = 0; i < 8; i++) send_byte(s[i], $urandom_range(0, 1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_hold_big",   32'(lb.cpu_hold),   32'd0);
        check("mid_hold_small", 32'(ls.cpu_hold),   32'd0);
        check("mid_cnt",        32'(lb.load_count), 32'd0);
        model_load(s, 1);
        read_words(0, "mid_w0");
        read_words(1, "mid_w1");
        rand_stream(s, 1);
        run_load(s, "restart", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sequence did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory stage that consumes the 16-bit byte-address PC from the fetch stage and returns the 32-bit instruction word. It also contains a UART-fed program loader: on request it takes a length-prefixed byte stream, writes it into the memory word by word, and holds the CPU while loading. It sits directly downstream of the PC register and upstream of decode.

## Interface
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (default 4096 words).
- NOP_WORD, 32'h0000_0013, word driven on `instr` while the CPU is held or after reset.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- pc  in  16  byte address from fetch. Updated on the negedge.
- instr  out  32  registered instruction word.
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- rx_data  in  8  received UART byte.
- load_start  in  1  single-cycle pulse that requests a program load.
- cpu_hold  out  1  high while loading. Drives the CPU-wide hold/reset.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  DEPTH_LOG2+1  number of words written by the last or current load.
- overflow  out  1  sticky. Set when the stream length exceeds the memory depth.
- misaligned  out  1  combinational: `pc[1:0] != 0`.

## Operation
- Word index = `pc[DEPTH_LOG2+1:2]`. Higher PC bits are ignored, so the address wraps modulo the memory depth.
- FSM states: RUN, LEN_LO, LEN_HI, DATA, DONE.
- RUN:
  - `cpu_hold` = 0.
  - `rx_valid` is ignored.
  - `load_start` → LEN_LO. Clear `load_count`, `overflow`, the byte counter and the word address.
- LEN_LO: on `rx_valid`, latch `N[7:0]` → LEN_HI.
- LEN_HI: on `rx_valid`, latch `N[15:8]`. Next state is DONE if N == 0, otherwise DATA.
- DATA: collect bytes little-endian with a 2-bit byte counter (byte 0 → bits [7:0]).
  - On the 4th byte, write the word at the word address, increment the address and `load_count`.
  - After the word-N write → DONE.
  - If the word address ≥ 2^DEPTH_LOG2, the word is not written. Its bytes are still consumed, `overflow` is set and `load_count` still increments.
- DONE: `load_done` = 1 for exactly one cycle, `cpu_hold` still 1 → RUN.
- `cpu_hold` = 1 in LEN_LO, LEN_HI, DATA and DONE.
- `load_start` outside RUN is ignored.
- `rx_valid` in the same cycle as an accepted `load_start` is ignored; the byte is not treated as LEN_LO.
- Memory contents are never cleared by reset; only state, counters and outputs are reset.
- The memory has no write path other than the loader.

## Timing
- Reset values:
  - state RUN.
  - `instr` = NOP_WORD.
  - `cpu_hold` = 0, `load_done` = 0.
  - `load_count` = 0, `overflow` = 0.
- Read is synchronous. `instr` is registered at the posedge after `pc` changes, giving a half-cycle from the negedge PC update, with a latency of 1 posedge.
- While `cpu_hold` = 1, and on the first posedge after it falls, `instr` = NOP_WORD.
- Real reads resume at the second posedge after DONE.
- The write occurs at the posedge sampling the 4th byte's `rx_valid`. A read of the same address in that cycle returns the old data (read-before-write).
- `load_count` updates in the same edge as the write.
- Reset mid-load: the next posedge returns to RUN with `cpu_hold` = 0. Words already written are kept; the partial word is dropped.
- `misaligned` has zero latency and is purely combinational on `pc`.

## Test plan
- Reset then `pc` = 0 → `instr` = 0x00000013, `cpu_hold` = 0, `load_count` = 0, `overflow` = 0.
- `load_start`, then bytes 02 00 | 93 00 50 00 | 13 01 A0 00 → `cpu_hold` high from the next edge. `load_done` pulses once, `load_count` = 2. Then `pc` = 0 → 0x00500093 and `pc` = 4 → 0x00A00113.
- `load_start`, then N = 0 (00 00) → DONE directly, `load_count` = 0, memory unchanged.
- DEPTH_LOG2 = 2 with N = 5 and 20 bytes → 4 words written, `overflow` = 1, `load_count` = 5. `pc` = 16 reads word 0 (wrap).
- Assert `reset` after 6 data bytes → state RUN, `cpu_hold` = 0. Word 0 is retained, word 1 is unwritten; a second `load_start` restarts the count.
- `pc` = 0x0002 → `misaligned` = 1 and `instr` = word 0. `rx_valid` pulses in RUN → no memory change. `load_start` during DATA → ignored.
